bp_cache: RTL and testbench
===========================

Name: bp_cache

Overview:
- Branch history table of 2-bit saturating counters, indexed directly by a low-order PC slice.
- Sits in the fetch stage, where it gives a registered taken/not-taken prediction for the address being fetched.
- Updated from the execute/resolve stage with the actual branch outcome.
- Read and write ports are independent and synchronous to one clock.

Parameters:
- ADDR_W, 8, index width; table depth is 2**ADDR_W entries (default 256).
- RESET_CTR, 2'b01, counter value loaded into every entry on reset (weak not-taken).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- addr  input  ADDR_W  read (predict) index.
- branch  output  1  registered prediction for addr: 1 = predict taken.
- w_addr  input  ADDR_W  update index.
- did_branch  input  1  resolved outcome for w_addr: 1 = taken, 0 = not taken.
- we  input  1  update enable; an update is applied only at a rising edge with we=1.

Behaviour:
- Storage: 2**ADDR_W entries, 2 bits each, held in flops so all entries clear together on reset.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Reset (rst_n=0, asynchronous): every entry is set to RESET_CTR and branch is set to 0 immediately. Both hold while rst_n=0; updates and reads are ignored.
- Read: at each rising edge, branch <= MSB of entry[addr].
  - Latency is 1 cycle: addr applied before edge N gives its prediction after edge N.
  - branch holds its value between edges.
- Update: at a rising edge with we=1, entry[w_addr] changes as follows.
  - did_branch=1: saturating increment; 11 stays 11.
  - did_branch=0: saturating decrement; 00 stays 00.
- Only one entry changes per cycle. With we=0 the table is unchanged.
- Transition summary:
  - 00 -> taken: 01; not-taken: 00.
  - 01 -> taken: 10; not-taken: 00.
  - 10 -> taken: 11; not-taken: 01.
  - 11 -> taken: 11; not-taken: 10.
- Write followed by read of the same index in the next cycle: the read returns the updated counter.
- Simultaneous read and write of the same index in one edge (without the optional feature): the read samples the pre-update value, i.e. read-old.
- Different indices in the same cycle are fully independent.
- Index arithmetic: no hashing and no wrap logic; addr and w_addr select an entry directly.
- Reset asserted mid-operation: all history is lost, every entry returns to RESET_CTR, and branch=0 on the next read.
- No X on branch after reset release; undriven (X) inputs are not a supported use.

Optional Feature:
- Macro BPCACHE_WR_BYPASS_EN.
- When defined: if we=1 and w_addr==addr at the same edge, branch is loaded with the MSB of the updated counter value (write-first forwarding). All other behaviour is unchanged.
- When not defined: read-old behaviour as specified above, with no comparator on the read path.

Test Plan:
- Hold rst_n=0 for 3 cycles, then release and sweep addr 0..255 with we=0 -> branch=0 throughout and after every read.
- For each index i: write taken (we=1, did_branch=1, w_addr=i), then set addr=i next cycle -> branch=1. Then write not-taken -> branch=0 (01->10->01).
- For each index, apply taken updates one at a time, reading branch after each -> 1, 1, 1, 1 (10, 11, 11 saturate). Then apply not-taken updates one at a time, reading branch after each -> 1, 0, 0, 0 (10, 01, 00, 00 saturate).
- From 00, apply taken updates one at a time, reading branch after each -> 0, 1, 1 (01, 10, 11).
- Isolation: update w_addr=5 to 11 while reading addr=6 -> branch=0. Then assert rst_n=0 mid-sequence -> branch=0 immediately, and addr=5 reads 0 after release.
- Same-cycle we=1, w_addr=addr=9 from 01, did_branch=1 -> branch=0 at that edge without BPCACHE_WR_BYPASS_EN, 1 with it. branch=1 on the following read in both builds.

Source files
------------

// File: rtl/bp_cache.sv
// Branch history table of 2-bit saturating counters, indexed directly by a PC slice.
// Optional write-first forwarding on the read path: define BPCACHE_WR_BYPASS_EN.
module bp_cache #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [1:0]  RESET_CTR = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic              branch,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic              did_branch,
    input  logic              we
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][1:0] r_table;
    logic                  r_branch;

    logic [1:0] w_cur_ctr;
    logic [1:0] w_next_ctr;
    logic [1:0] w_rd_ctr;
    logic       w_rd_taken;

    function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

    always_comb begin
        w_cur_ctr  = r_table[w_addr];
        w_next_ctr = sat_next(w_cur_ctr, did_branch);
        w_rd_ctr   = r_table[addr];
    end

`ifdef BPCACHE_WR_BYPASS_EN
    // Same-index update in this edge: forward the post-update counter.
    logic w_bypass;
    always_comb begin
        w_bypass   = we && (w_addr == addr);
        w_rd_taken = w_bypass ? w_next_ctr[1] : w_rd_ctr[1];
    end
`else
    always_comb begin
        w_rd_taken = w_rd_ctr[1];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= RESET_CTR;
            end
        end else if (we) begin
            r_table[w_addr] <= w_next_ctr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch <= 1'b0;
        end else begin
            r_branch <= w_rd_taken;
        end
    end

    assign branch = r_branch;

endmodule

// File: tb/tb_bp_cache.sv
// Scoreboard bench for bp_cache: stimulus queues expected predictions, a monitor checks them.
module tb_bp_cache;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned NSTEP  = 13;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic              branch;
    logic [ADDR_W-1:0] w_addr;
    logic              did_branch;
    logic              we;

    typedef struct {
        logic  exp;
        string name;
    } exp_t;

    exp_t exp_q[$];
    logic rd_v;
    logic chk_v;
    int   n_pass;
    int   n_total;

    bp_cache #(
        .ADDR_W    (ADDR_W),
        .RESET_CTR (2'b01)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .branch     (branch),
        .w_addr     (w_addr),
        .did_branch (did_branch),
        .we         (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Read issued before edge N is observed after edge N.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) chk_v <= 1'b0;
        else        chk_v <= rd_v;
    end

    always @(negedge clk) begin
        if (chk_v) begin
            if (exp_q.size() == 0) begin
                check("monitor_underflow", 1, 0);
            end else begin
                exp_t item;
                item = exp_q.pop_front();
                check(item.name, int'(branch), int'(item.exp));
            end
        end
    end

    task automatic cyc(input logic we_v, input logic [ADDR_W-1:0] wa, input logic db,
                       input logic rd, input logic [ADDR_W-1:0] ra, input logic e,
                       input string name);
        exp_t item;
        @(negedge clk);
        we         = we_v;
        w_addr     = wa;
        did_branch = db;
        addr       = ra;
        rd_v       = rd;
        if (rd) begin
            item.exp  = e;
            item.name = name;
            exp_q.push_back(item);
        end
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, "");
    endtask

    task automatic do_reset(input string tag);
        idle();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        rd_v  = 1'b0;
        we    = 1'b0;
        #1;
        check({tag, "_immediate"}, int'(branch), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check({tag, "_hold"}, int'(branch), 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic seq_db  [NSTEP];
        logic seq_exp [NSTEP];
        logic byp_exp;
        seq_db  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b1};
        seq_exp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1};
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b0;
        rd_v       = 1'b0;
        we         = 1'b0;
        addr       = '0;
        w_addr     = '0;
        did_branch = 1'b0;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_hold", int'(branch), 0);
        end
        rst_n = 1'b1;

        // All entries start weak not-taken.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, ADDR_W'(i), 1'b0, $sformatf("sweep i=%0d", i));
        end

        // Walk every entry through both saturation ends.
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < NSTEP; s++) begin
                cyc(1'b1, ADDR_W'(i), seq_db[s], 1'b0, '0, 1'b0, "");
                cyc(1'b0, '0, 1'b0, 1'b1, ADDR_W'(i), seq_exp[s],
                    $sformatf("seq i=%0d step=%0d", i, s));
            end
        end

        do_reset("reset_mid");

        // Updates to 5 must not disturb reads of 6.
        cyc(1'b1, 8'd5, 1'b1, 1'b1, 8'd6, 1'b0, "iso read6 a");
        cyc(1'b1, 8'd5, 1'b1, 1'b1, 8'd6, 1'b0, "iso read6 b");
        cyc(1'b0, '0, 1'b0, 1'b1, 8'd6, 1'b0, "iso read6 c");
        cyc(1'b0, '0, 1'b0, 1'b1, 8'd5, 1'b1, "iso read5 strong");

        do_reset("reset_iso");
        cyc(1'b0, '0, 1'b0, 1'b1, 8'd5, 1'b0, "post_reset read5");

        // Same-edge read and write of index 9 from 01.
`ifdef BPCACHE_WR_BYPASS_EN
        byp_exp = 1'b1;
`else
        byp_exp = 1'b0;
`endif
        cyc(1'b1, 8'd9, 1'b1, 1'b1, 8'd9, byp_exp, "same_edge rw9");
        cyc(1'b0, '0, 1'b0, 1'b1, 8'd9, 1'b1, "after rw9");

        idle();
        idle();
        idle();
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
